alu_result_fifo: RTL

Result buffer directly downstream of the 8-bit `alu`. It captures each ALU output word along with its tag into a small first-word-fall-through FIFO:
- the tag is the 3-bit opcode;
- the flags are carry and zero;
- the product is the optional 16-bit `mulresult`.

Entries are presented to the consumer (writeback/display logic) over a valid/ready handshake. The block decouples the combinational ALU from a consumer that may stall. It also keeps an overflow flag and a retired-result counter.

---
 rtl/alu_result_fifo.sv | 119 +++++++++++
 1 files changed

// File: rtl/alu_result_fifo.sv
// Tag-carrying FWFT result buffer behind the 8-bit ALU; optional product storage under ALU_RESFIFO_MUL_EN.
// Latency: an entry pushed on edge N is presented on out_* right after edge N; one push and one pop per cycle.
// Backpressure: in_ready drops only when full (registered count); pushing while full is dropped and flagged in overflow.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          result,
    input  logic [15:0]         mulresult,
    input  logic                carry,
    input  logic                zero,
    input  logic [2:0]          opcode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_result,
    output logic [15:0]         out_mulresult,
    output logic                out_carry,
    output logic                out_zero,
    output logic [2:0]          out_opcode,
    output logic [PTR_W:0]      count,
    output logic                overflow,
    input  logic                clr_overflow,
    output logic [7:0]          retired
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    logic [7:0] mem_result [DEPTH];
    logic [2:0] mem_opcode [DEPTH];
    logic       mem_carry  [DEPTH];
    logic       mem_zero   [DEPTH];

    // Full/empty come only from the registered count, so in_ready never sees out_ready.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A blocked push while full sets the flag even when a pop frees a slot this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= 8'd0;
        end else if (pop) begin
            retired <= retired + 8'd1;
        end
    end

    // Storage is left unreset; every read is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr] <= result;
            mem_opcode[wr_ptr] <= opcode;
            mem_carry[wr_ptr]  <= carry;
            mem_zero[wr_ptr]   <= zero;
        end
    end

    assign out_result = out_valid ? mem_result[rd_ptr] : 8'd0;
    assign out_opcode = out_valid ? mem_opcode[rd_ptr] : 3'd0;
    assign out_carry  = out_valid ? mem_carry[rd_ptr]  : 1'b0;
    assign out_zero   = out_valid ? mem_zero[rd_ptr]   : 1'b0;

`ifdef ALU_RESFIFO_MUL_EN
    logic [15:0] mem_mul [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_mul[wr_ptr] <= mulresult;
        end
    end

    assign out_mulresult = out_valid ? mem_mul[rd_ptr] : 16'h0000;
`else
    logic unused_mulresult;

    assign unused_mulresult = ^mulresult;
    assign out_mulresult    = 16'h0000;
`endif

endmodule
